// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel (AR/R) between NUM_REQ requesters.
// One burst in flight: the grant is held from AR acceptance until the RLAST beat handshakes.
module axi4_rd_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned IDXW       = $clog2(NUM_REQ)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_REQ-1:0]           s_arvalid,
  output logic [NUM_REQ-1:0]           s_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]         s_arlen,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  s_arid,
  output logic [NUM_REQ-1:0]           s_rvalid,
  input  logic [NUM_REQ-1:0]           s_rready,
  output logic [DATA_WIDTH-1:0]        s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rlast,
  output logic [ID_WIDTH-1:0]          s_rid,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  output logic [ADDR_WIDTH-1:0]        m_araddr,
  output logic [7:0]                   m_arlen,
  output logic [2:0]                   m_arsize,
  output logic [1:0]                   m_arburst,
  output logic [ID_WIDTH+IDXW-1:0]     m_arid,
  input  logic                         m_rvalid,
  output logic                         m_rready,
  input  logic [DATA_WIDTH-1:0]        m_rdata,
  input  logic [1:0]                   m_rresp,
  input  logic                         m_rlast,
  input  logic [ID_WIDTH+IDXW-1:0]     m_rid
);

  typedef enum logic [1:0] {IDLE, AR, R} state_t;

  state_t              state, state_nxt;
  logic [IDXW-1:0]     ptr, gnt, win;
  logic [IDXW:0]       cand;
  logic                found;
  logic [ID_WIDTH-1:0] arid_q;

  // Scan from ptr upward with wrap; the extra bit in cand holds ptr+i before the modulo.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(i);
      if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
      if (!found && s_arvalid[cand[IDXW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_arready = '0;
    s_rvalid  = '0;
    m_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found && aresetn) begin
          s_arready[win] = 1'b1;
          state_nxt      = AR;
        end
      end
      AR: begin
        if (m_arready) state_nxt = R;
      end
      R: begin
        s_rvalid[gnt] = m_rvalid;
        m_rready      = s_rready[gnt];
        if (m_rvalid && s_rready[gnt] && m_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      ptr      <= '0;
      gnt      <= '0;
      m_araddr <= '0;
      m_arlen  <= '0;
      arid_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        gnt      <= win;
        m_araddr <= s_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen  <= s_arlen[win*8 +: 8];
        arid_q   <= s_arid[win*ID_WIDTH +: ID_WIDTH];
      end
      if (state == R && m_rvalid && m_rready && m_rlast)
        ptr <= (gnt == IDXW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
    end
  end

  assign m_arvalid = (state == AR);
  assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_arburst = 2'b01;
  assign m_arid    = {gnt, arid_q};

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;
  assign s_rid   = m_rid[ID_WIDTH-1:0];

`ifndef SYNTHESIS
  a_ar_stable: assert property (@(posedge aclk) disable iff (!aresetn)
    m_arvalid && !m_arready |=> m_arvalid && $stable(m_araddr) && $stable(m_arlen) && $stable(m_arid));
  a_rvalid_1h: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(s_rvalid));
  a_arready_1h: assert property (@(posedge aclk) disable iff (!aresetn) $onehot0(s_arready));
  a_rid_gnt: assert property (@(posedge aclk) disable iff (!aresetn)
    (state == R && m_rvalid) |-> m_rid[ID_WIDTH+IDXW-1:ID_WIDTH] == gnt);
  a_r_in_r: assert property (@(posedge aclk) disable iff (!aresetn) m_rvalid |-> state == R);
`endif

endmodule
